// File: rtl/worker_batch_seq_pkg.sv
// Shared definitions for the worker batch sequencer: state encoding and
// derived SRAM address widths.
package worker_batch_seq_pkg;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StClear = 3'd1,
        StRun   = 3'd2,
        StStep  = 3'd3,
        StDone  = 3'd4,
        StFlush = 3'd5
    } state_t;

    // vid address = {iteration LSBs, batch bits above the sub-batch field}
    function automatic int unsigned vid_addr_space(input int unsigned vid_iter_bits,
                                                   input int unsigned batch_bw,
                                                   input int unsigned sub_bat_bw);
        return vid_iter_bits + batch_bw - sub_bat_bw;
    endfunction

    // dist address = {vid index, sub-batch}
    function automatic int unsigned dist_addr_space(input int unsigned vid_idx_bw,
                                                    input int unsigned sub_bat_bw);
        return vid_idx_bw + sub_bat_bw;
    endfunction

endpackage

// File: rtl/worker_batch_seq.sv
// Batch sequencer for one graph worker: runs iter_num clear/run iterations per batch,
// drives SRAM read addresses, gates worker writes, and adds abort/watchdog handling.
module worker_batch_seq
    import worker_batch_seq_pkg::*;
#(
    parameter int unsigned BATCH_BW      = 8,
    parameter int unsigned SUB_BAT_BW    = 4,
    parameter int unsigned VID_IDX_BW    = 12,
    parameter int unsigned ITER_BW       = 4,
    parameter int unsigned VID_ITER_BITS = 1,
    parameter int unsigned TIMEOUT_BW    = 16,
    parameter int unsigned WCNT_BW       = 16,
    localparam int unsigned VID_ADDR_SPACE  = vid_addr_space(VID_ITER_BITS, BATCH_BW, SUB_BAT_BW),
    localparam int unsigned DIST_ADDR_SPACE = dist_addr_space(VID_IDX_BW, SUB_BAT_BW)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       abort,
    input  logic [BATCH_BW-1:0]        batch_num,
    input  logic [ITER_BW-1:0]         iter_num,
    input  logic [TIMEOUT_BW-1:0]      timeout_limit,
    input  logic                       wk_batch_finish,
    input  logic [SUB_BAT_BW-1:0]      wk_sub_bat,
    input  logic [VID_IDX_BW-1:0]      wk_vid,
    input  logic                       wk_wen,
    output logic                       wk_en,
    output logic                       wk_rst,
    output logic [VID_ADDR_SPACE-1:0]  vid_sram_raddr,
    output logic [DIST_ADDR_SPACE-1:0] dist_sram_raddr,
    output logic [SUB_BAT_BW-1:0]      loc_sram_raddr,
    output logic                       sram_wen,
    output logic                       busy,
    output logic                       done,
    output logic [ITER_BW-1:0]         iter_cnt,
    output logic [WCNT_BW-1:0]         wr_cnt,
    output logic                       timeout_err
);

    state_t                  r_state;
    state_t                  w_state_d;
    logic [BATCH_BW-1:0]     r_batch;
    logic [ITER_BW-1:0]      r_iter;
    logic [TIMEOUT_BW-1:0]   r_limit;
    logic [ITER_BW-1:0]      r_iter_cnt;
    logic [WCNT_BW-1:0]      r_wr_cnt;
    logic                    r_timeout_err;
    logic [TIMEOUT_BW-1:0]   r_wdog;

    logic                    w_run;
    logic                    w_accept;
    logic                    w_step;
    logic                    w_timeout;
    logic [ITER_BW-1:0]      w_iter_inc;
    logic [TIMEOUT_BW-1:0]   w_wdog_inc;

    assign w_run      = (r_state == StRun);
    assign w_iter_inc = r_iter_cnt + 1'b1;
    assign w_wdog_inc = r_wdog + 1'b1;

    // Next-state decode; priority in RUN is abort > timeout > batch_finish
    always_comb begin
        w_state_d = r_state;
        w_accept  = 1'b0;
        w_step    = 1'b0;
        w_timeout = 1'b0;
        case (r_state)
            StIdle: begin
                if (start) begin
                    w_accept  = 1'b1;
                    w_state_d = (iter_num == '0) ? StDone : StClear;
                end
            end
            StClear: begin
                w_state_d = abort ? StFlush : StRun;
            end
            StRun: begin
                if (abort) begin
                    w_state_d = StFlush;
                end else if ((r_limit != '0) && (w_wdog_inc == r_limit)) begin
                    w_timeout = 1'b1;
                    w_state_d = StFlush;
                end else if (wk_batch_finish) begin
                    w_state_d = StStep;
                end
            end
            StStep: begin
                if (abort) begin
                    w_state_d = StFlush;
                end else begin
                    w_step    = 1'b1;
                    w_state_d = (w_iter_inc == r_iter) ? StDone : StClear;
                end
            end
            StDone:  w_state_d = StIdle;
            StFlush: w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    // Latched batch parameters, counters, watchdog and sticky timeout flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_batch       <= '0;
            r_iter        <= '0;
            r_limit       <= '0;
            r_iter_cnt    <= '0;
            r_wr_cnt      <= '0;
            r_timeout_err <= 1'b0;
            r_wdog        <= '0;
        end else begin
            // Watchdog only runs in RUN, so it restarts from 0 on every entry
            r_wdog <= w_run ? w_wdog_inc : '0;
            if (w_accept) begin
                r_batch       <= batch_num;
                r_iter        <= iter_num;
                r_limit       <= timeout_limit;
                r_iter_cnt    <= '0;
                r_wr_cnt      <= '0;
                r_timeout_err <= 1'b0;
            end else begin
                if (w_step) begin
                    r_iter_cnt <= w_iter_inc;
                end
                if (w_timeout) begin
                    r_timeout_err <= 1'b1;
                end
                if (sram_wen && (r_wr_cnt != '1)) begin
                    r_wr_cnt <= r_wr_cnt + 1'b1;
                end
            end
        end
    end

    assign wk_en           = w_run;
    assign wk_rst          = (r_state == StIdle) || (r_state == StClear) || (r_state == StFlush);
    assign busy            = (r_state != StIdle);
    assign done            = (r_state == StDone);
    assign sram_wen        = wk_wen & w_run;
    assign vid_sram_raddr  = {r_iter_cnt[VID_ITER_BITS-1:0], r_batch[BATCH_BW-1:SUB_BAT_BW]};
    assign dist_sram_raddr = w_run ? {wk_vid, wk_sub_bat} : '0;
    assign loc_sram_raddr  = w_run ? wk_sub_bat : '0;
    assign iter_cnt        = r_iter_cnt;
    assign wr_cnt          = r_wr_cnt;
    assign timeout_err     = r_timeout_err;

endmodule

// File: tb/tb_worker_batch_seq.sv
// Self-checking bench for worker_batch_seq: a batch-level reference model pushes
// expected outcomes and vid addresses into queues; a negedge monitor compares.
module tb_worker_batch_seq;

    localparam int P_RST   = 0;
    localparam int P_IDLE  = 1;
    localparam int P_CLEAR = 2;
    localparam int P_RUN   = 3;
    localparam int P_STEP  = 4;
    localparam int P_DONE  = 5;
    localparam int P_FLUSH = 6;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic [7:0]  batch_num;
    logic [3:0]  iter_num;
    logic [15:0] timeout_limit;
    logic        wk_batch_finish;
    logic [3:0]  wk_sub_bat;
    logic [11:0] wk_vid;
    logic        wk_wen;
    logic        wk_en;
    logic        wk_rst;
    logic [4:0]  vid_sram_raddr;
    logic [15:0] dist_sram_raddr;
    logic [3:0]  loc_sram_raddr;
    logic        sram_wen;
    logic        busy;
    logic        done;
    logic [3:0]  iter_cnt;
    logic [15:0] wr_cnt;
    logic        timeout_err;

    worker_batch_seq dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .abort           (abort),
        .batch_num       (batch_num),
        .iter_num        (iter_num),
        .timeout_limit   (timeout_limit),
        .wk_batch_finish (wk_batch_finish),
        .wk_sub_bat      (wk_sub_bat),
        .wk_vid          (wk_vid),
        .wk_wen          (wk_wen),
        .wk_en           (wk_en),
        .wk_rst          (wk_rst),
        .vid_sram_raddr  (vid_sram_raddr),
        .dist_sram_raddr (dist_sram_raddr),
        .loc_sram_raddr  (loc_sram_raddr),
        .sram_wen        (sram_wen),
        .busy            (busy),
        .done            (done),
        .iter_cnt        (iter_cnt),
        .wr_cnt          (wr_cnt),
        .timeout_err     (timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int iter;
        int wr;
        int to;
        int dn;
    } outcome_t;

    outcome_t   out_q[$];
    logic [4:0] vid_q[$];
    int         plan_len[16];
    int         exp_ph = P_RST;
    int         n_tests = 0;
    int         n_fail = 0;

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Monitor: per-cycle output checks against the model phase, plus queue pops
    int         prev_ph = P_RST;
    int         done_seen = 0;
    logic [4:0] cur_vid = '0;
    always @(negedge clk) begin
        if (exp_ph == P_RST) begin
            chk("rst_wk_rst", 32'(wk_rst), 32'd1);
            chk("rst_wk_en", 32'(wk_en), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_done", 32'(done), 32'd0);
            chk("rst_vid", 32'(vid_sram_raddr), 32'd0);
            chk("rst_dist", 32'(dist_sram_raddr), 32'd0);
            chk("rst_loc", 32'(loc_sram_raddr), 32'd0);
            chk("rst_sram_wen", 32'(sram_wen), 32'd0);
            chk("rst_iter_cnt", 32'(iter_cnt), 32'd0);
            chk("rst_wr_cnt", 32'(wr_cnt), 32'd0);
            chk("rst_timeout_err", 32'(timeout_err), 32'd0);
            done_seen = 0;
        end else begin
            chk("wk_en", 32'(wk_en), 32'(exp_ph == P_RUN));
            if (exp_ph == P_IDLE || exp_ph == P_CLEAR || exp_ph == P_RUN || exp_ph == P_FLUSH)
                chk("wk_rst", 32'(wk_rst), 32'(exp_ph != P_RUN));
            chk("busy", 32'(busy), 32'(exp_ph != P_IDLE));
            chk("done", 32'(done), 32'(exp_ph == P_DONE));
            chk("sram_wen", 32'(sram_wen), 32'((exp_ph == P_RUN) && wk_wen));
            chk("dist_addr", 32'(dist_sram_raddr),
                (exp_ph == P_RUN) ? 32'({wk_vid, wk_sub_bat}) : 32'd0);
            chk("loc_addr", 32'(loc_sram_raddr), (exp_ph == P_RUN) ? 32'(wk_sub_bat) : 32'd0);
            if (done) done_seen++;
            if (exp_ph == P_CLEAR && prev_ph != P_CLEAR) begin
                if (vid_q.size() == 0) begin
                    chk("vid_q_underflow", 32'd1, 32'd0);
                end else begin
                    cur_vid = vid_q.pop_front();
                end
            end
            if (exp_ph == P_CLEAR || exp_ph == P_RUN)
                chk("vid_addr", 32'(vid_sram_raddr), 32'(cur_vid));
            if (exp_ph == P_IDLE && prev_ph != P_IDLE && prev_ph != P_RST) begin
                if (out_q.size() == 0) begin
                    chk("out_q_underflow", 32'd1, 32'd0);
                end else begin
                    outcome_t o;
                    o = out_q.pop_front();
                    chk("iter_cnt", 32'(iter_cnt), 32'(o.iter));
                    chk("wr_cnt", 32'(wr_cnt), 32'(o.wr));
                    chk("timeout_err", 32'(timeout_err), 32'(o.to));
                    chk("done_pulses", 32'(done_seen), 32'(o.dn));
                end
                done_seen = 0;
            end
        end
        prev_ph = exp_ph;
    end

    // One clock cycle of stimulus; ph is the phase the model expects the DUT to be in
    task automatic drive(input int ph, input bit st, input bit ab, input bit fin, input bit wen);
        start           = st;
        abort           = ab;
        wk_batch_finish = fin;
        wk_wen          = wen;
        wk_vid          = 12'($urandom);
        wk_sub_bat      = 4'($urandom);
        if (!st) begin
            // Scramble batch inputs to show the latched copies are used
            batch_num     = 8'($urandom);
            iter_num      = 4'($urandom);
            timeout_limit = 16'($urandom);
        end
        exp_ph = ph;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(P_IDLE, 1'b0, 1'($urandom), 1'($urandom), 1'($urandom));
    endtask

    function automatic bit rnd_start();
        return ($urandom_range(0, 3) == 0);
    endfunction

    // Run one batch: model computes the outcome first, then stimulus follows the schedule
    task automatic run_batch(input logic [7:0] b, input int iters, input int limit,
                             input int ab_i, input int ab_c);
        int       endc[16];
        int       rsn[16];
        bit       wq[$];
        outcome_t o;
        o.iter = 0;
        o.wr   = 0;
        o.to   = 0;
        o.dn   = 0;
        for (int i = 0; i < iters; i++) begin
            endc[i] = plan_len[i];
            rsn[i]  = 0;
            if (limit != 0 && limit <= endc[i]) begin
                endc[i] = limit;
                rsn[i]  = 1;
            end
            if (i == ab_i && ab_c <= endc[i]) begin
                endc[i] = ab_c;
                rsn[i]  = 2;
            end
            vid_q.push_back({i[0], b[7:4]});
            for (int j = 0; j < endc[i]; j++) begin
                bit w;
                w = 1'($urandom);
                wq.push_back(w);
                o.wr += int'(w);
            end
            if (rsn[i] != 0) begin
                o.to = (rsn[i] == 1) ? 1 : 0;
                break;
            end
            o.iter++;
        end
        if (o.iter == iters) o.dn = 1;
        out_q.push_back(o);

        batch_num     = b;
        iter_num      = 4'(iters);
        timeout_limit = 16'(limit);
        drive(P_IDLE, 1'b1, 1'($urandom), 1'($urandom), 1'($urandom));
        if (iters == 0) begin
            drive(P_DONE, rnd_start(), 1'b0, 1'($urandom), 1'($urandom));
            return;
        end
        for (int i = 0; i < iters; i++) begin
            drive(P_CLEAR, rnd_start(), 1'b0, 1'($urandom), 1'($urandom));
            for (int j = 1; j <= endc[i]; j++) begin
                drive(P_RUN, rnd_start(), (j == endc[i]) && (rsn[i] == 2),
                      (j == plan_len[i]), wq.pop_front());
            end
            if (rsn[i] != 0) begin
                drive(P_FLUSH, rnd_start(), 1'($urandom), 1'($urandom), 1'($urandom));
                return;
            end
            drive(P_STEP, rnd_start(), 1'b0, 1'($urandom), 1'($urandom));
        end
        drive(P_DONE, rnd_start(), 1'($urandom), 1'($urandom), 1'($urandom));
    endtask

    initial begin
        rst             = 1'b1;
        start           = 1'b0;
        abort           = 1'b0;
        batch_num       = '0;
        iter_num        = '0;
        timeout_limit   = '0;
        wk_batch_finish = 1'b0;
        wk_sub_bat      = '0;
        wk_vid          = '0;
        wk_wen          = 1'b0;
        exp_ph          = P_RST;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        idle(2);

        // Normal two-iteration batch: vid addr 0x0A then 0x1A
        plan_len[0] = 10;
        plan_len[1] = 10;
        run_batch(8'hA5, 2, 0, -1, 0);
        idle(2);

        // Zero iterations: straight to DONE
        run_batch(8'h11, 0, 0, -1, 0);
        idle(1);

        // Watchdog fires after 5 RUN cycles; next start clears timeout_err
        plan_len[0] = 100;
        run_batch(8'h22, 1, 5, -1, 0);
        idle(2);
        plan_len[0] = 3;
        run_batch(8'h33, 1, 0, -1, 0);
        idle(1);

        // Abort and finish in the same RUN cycle: abort wins
        plan_len[0] = 6;
        plan_len[1] = 6;
        run_batch(8'h5A, 2, 0, 0, 6);
        idle(1);

        // Timeout and finish in the same cycle: timeout wins
        plan_len[0] = 4;
        run_batch(8'h77, 1, 4, -1, 0);
        idle(1);

        // Reset mid-RUN returns to reset values with no done pulse
        vid_q.push_back({1'b0, 4'h3});
        batch_num     = 8'h3C;
        iter_num      = 4'd3;
        timeout_limit = 16'd0;
        drive(P_IDLE, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(P_CLEAR, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (3) drive(P_RUN, 1'b0, 1'b0, 1'b0, 1'b1);
        rst    = 1'b1;
        exp_ph = P_RST;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        idle(2);

        // Long batch exercises full-width iteration compare and vid wrap
        for (int i = 0; i < 16; i++) plan_len[i] = 1 + (i % 3);
        run_batch(8'hC3, 15, 0, -1, 0);
        idle(1);

        // Randomized batches
        for (int n = 0; n < 40; n++) begin
            int iters;
            int limit;
            int ab_i;
            int ab_c;
            iters = ($urandom_range(0, 7) == 0) ? int'($urandom_range(6, 15))
                                                : int'($urandom_range(0, 5));
            for (int i = 0; i < 16; i++) plan_len[i] = int'($urandom_range(1, 8));
            case ($urandom_range(0, 3))
                0:       limit = int'($urandom_range(1, 8));
                1:       limit = 200;
                default: limit = 0;
            endcase
            if ($urandom_range(0, 3) == 0 && iters > 0) begin
                ab_i = int'($urandom_range(0, iters - 1));
                ab_c = int'($urandom_range(1, 8));
            end else begin
                ab_i = -1;
                ab_c = 0;
            end
            run_batch(8'($urandom), iters, limit, ab_i, ab_c);
            idle(int'($urandom_range(1, 3)));
        end

        idle(3);
        chk("out_q_drained", 32'(out_q.size()), 32'd0);
        chk("vid_q_drained", 32'(vid_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
